rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- Reorder buffer storage plus in-order commit stage: the producer end of the retire interface the rename stage consumes (c_retire_i, c_retire_info_i, c_flush_i).
- Records up to 2 dispatched instructions per cycle at rename-allocated ROB ids and collects up to 2 writebacks per cycle.
- Retires up to 2 completed instructions per cycle from the head, in program order.
- Raises a one-cycle flush when a retiring instruction carries an exception or is a flush instruction.

Parameters:
DEPTH, 64, number of ROB entries (power of two)
ROB_WIDTH, 6, log2(DEPTH), width of a ROB id
DATA_WIDTH, 32, result data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
dispatch_valid_i  input  2  per-slot dispatch strobe; slot 0 is older
dispatch_robid_i  input  2xROB_WIDTH  ROB id allocated by rename for each slot
dispatch_arfid_i  input  2x5  architectural destination register
dispatch_wreg_i  input  2  instruction writes a register
dispatch_check_i  input  2  rename check bit, returned at retire
dispatch_flush_inst_i  input  2  instruction requires pipeline flush at retire
wb_valid_i  input  2  writeback strobes
wb_robid_i  input  2xROB_WIDTH  completing entry id
wb_data_i  input  2xDATA_WIDTH  result
wb_exc_i  input  2  completing instruction raised an exception
c_retire_o  output  2  retire strobes; bit1 only when bit0 is set
c_retire_info_o  output  2xretire_pkg_t  per slot: arf_id, rob_id, w_valid, w_check, data
c_flush_o  output  1  one-cycle flush pulse
c_flush_robid_o  output  ROB_WIDTH  id of the instruction that caused the flush

Behaviour:
- Reset is asynchronous, active-high, and independent of clk.
- Reset values:
  - All entry valid/done bits = 0; head = 0.
  - c_retire_o = 0, c_retire_info_o = 0, c_flush_o = 0, c_flush_robid_o = 0.
- Per-entry state: valid, done, exc, flush_req, arf_id, wreg, check, data.
- Dispatch (slot i asserted): entry[robid] gets valid=1, done=0, exc=0, plus the fields from the dispatch inputs.
- Writeback (slot i asserted) to a valid entry: done=1, data and exc written. Writeback to an invalid entry is ignored.
- Dispatch and writeback to the same id in the same cycle: dispatch wins and the writeback is dropped. Upstream must not produce this.
- Retire selection is combinational on current registered state; outputs are registered, so a retire is visible the cycle after the head becomes done.
  - h0 = head, h1 = head+1, both mod DEPTH (wraps from DEPTH-1 to 0).
  - Slot0 retires when entry[h0] is valid & done.
  - Slot1 retires when slot0 retires, entry[h0] has no exc/flush_req, and entry[h1] is valid & done.
- Retired entries: valid cleared; head advances by the retire count.
- c_retire_info_o[i] fields:
  - arf_id = entry arf_id
  - rob_id = entry id
  - w_valid = wreg & ~exc & (arf_id != 0)
  - w_check = check
  - data = data
- Flush:
  - The last retiring entry has exc=1 or flush_req=1 → c_flush_o=1 in the same output cycle as its retire strobe, and c_flush_robid_o = its id.
  - An excepting entry still retires (strobe set) with w_valid=0.
  - On the cycle c_flush_o is high, all entries are invalidated and head is set to 0, matching rename's pointer reset. Dispatch and writeback inputs in that cycle are ignored.
  - c_flush_o is never high for two consecutive cycles.
- Empty ROB: no retire, outputs 0.
- Full ROB: rename throttles allocation; this block does no overflow checking.
- c_retire_o bit pattern 2'b10 is illegal and never produced.

Test Plan:
- Reset, then dispatch ids 0,1 (arf 5,6, wreg=1, check=1,0); writeback id1 data 0xB then id0 data 0xA → cycle after id0 done: c_retire_o=2'b11, info[0]={arf5,rob0,w_valid1,check1,0xA}, info[1]={arf6,rob1,w_valid1,check0,0xB}.
- Out-of-order completion: id2 not done, id3 done → no retire; once id2 done → both retire in one cycle, head=4.
- Wrap: head=63, dispatch ids 63,0, both done → c_retire_o=2'b11 with rob_id 63 then 0; head becomes 1.
- Exception: id4 done with exc=1, id5 done → c_retire_o=2'b01, w_valid=0, c_flush_o=1, c_flush_robid_o=4; next cycle c_flush_o=0, head=0, and the stale id5 never retires.
- arf_id=0 with wreg=1 → retire with w_valid=0; flush_inst at slot1 position → both retire, c_flush_o=1, c_flush_robid_o=slot1 id.
- Assert rst mid-operation asynchronously → all outputs 0 before the next clock edge; a subsequent writeback with no prior dispatch produces no retire.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer storage plus in-order commit stage.
//
// The retire_pkg package supplies the per-slot retire record handed to rename.
// Its widths must match the module's ROB_WIDTH / DATA_WIDTH parameters.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   dispatch_*               up to two dispatches per cycle (slot 0 older),
//                            written at the rename-allocated ROB id
//   wb_*                     up to two writebacks per cycle (data + exception)
//   c_retire_o               registered retire strobes (2'b10 never produced)
//   c_retire_info_o          registered per-slot retire record
//   c_flush_o                one-cycle flush pulse, with the last retiring entry
//   c_flush_robid_o          ROB id of the instruction causing the flush

package retire_pkg;
  localparam int unsigned ROB_WIDTH  = 6;
  localparam int unsigned DATA_WIDTH = 32;

  typedef struct packed {
    logic [4:0]            arf_id;
    logic [ROB_WIDTH-1:0]  rob_id;
    logic                  w_valid;
    logic                  w_check;
    logic [DATA_WIDTH-1:0] data;
  } retire_pkg_t;
endpackage

module rob_commit #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ROB_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       dispatch_valid_i,
  input  logic [1:0][ROB_WIDTH-1:0]        dispatch_robid_i,
  input  logic [1:0][4:0]                  dispatch_arfid_i,
  input  logic [1:0]                       dispatch_wreg_i,
  input  logic [1:0]                       dispatch_check_i,
  input  logic [1:0]                       dispatch_flush_inst_i,
  input  logic [1:0]                       wb_valid_i,
  input  logic [1:0][ROB_WIDTH-1:0]        wb_robid_i,
  input  logic [1:0][DATA_WIDTH-1:0]       wb_data_i,
  input  logic [1:0]                       wb_exc_i,
  output logic [1:0]                       c_retire_o,
  output retire_pkg::retire_pkg_t [1:0]    c_retire_info_o,
  output logic                             c_flush_o,
  output logic [ROB_WIDTH-1:0]             c_flush_robid_o
);

  // Entry state; valid/done are reset, payload is qualified by valid.
  logic [DEPTH-1:0]      valid;
  logic [DEPTH-1:0]      done;
  logic [DEPTH-1:0]      exc;
  logic [DEPTH-1:0]      flush_req;
  logic [DEPTH-1:0]      wreg;
  logic [DEPTH-1:0]      check;
  logic [4:0]            arf_id [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ROB_WIDTH-1:0]  head;

  logic [ROB_WIDTH-1:0]  h0, h1;
  logic                  r0, r1;
  logic                  flush_nxt;
  logic [ROB_WIDTH-1:0]  flush_id;
  logic [1:0]            disp_ok;
  logic [1:0]            wb_ok;
  retire_pkg::retire_pkg_t [1:0] info_nxt;

  function automatic retire_pkg::retire_pkg_t mk_info(
    input logic [4:0]            arf,
    input logic [ROB_WIDTH-1:0]  id,
    input logic                  wr,
    input logic                  ex,
    input logic                  chk,
    input logic [DATA_WIDTH-1:0] d
  );
    retire_pkg::retire_pkg_t r;
    r.arf_id  = arf;
    r.rob_id  = id;
    r.w_valid = wr & ~ex & (arf != 5'd0);
    r.w_check = chk;
    r.data    = d;
    return r;
  endfunction

  always_comb begin
    h0 = head;
    h1 = head + ROB_WIDTH'(1);

    // While the flush pulse is out, the ROB is being cleared: nothing retires,
    // which also keeps c_flush_o from being high two cycles running.
    r0 = ~c_flush_o & valid[h0] & done[h0];
    r1 = r0 & ~exc[h0] & ~flush_req[h0] & valid[h1] & done[h1];

    flush_nxt = 1'b0;
    flush_id  = '0;
    if (r1) begin
      flush_nxt = exc[h1] | flush_req[h1];
      flush_id  = h1;
    end else if (r0) begin
      flush_nxt = exc[h0] | flush_req[h0];
      flush_id  = h0;
    end

    info_nxt = '0;
    if (r0) info_nxt[0] = mk_info(arf_id[h0], h0, wreg[h0], exc[h0], check[h0], data_q[h0]);
    if (r1) info_nxt[1] = mk_info(arf_id[h1], h1, wreg[h1], exc[h1], check[h1], data_q[h1]);

    disp_ok = dispatch_valid_i & {2{~c_flush_o}};

    // A writeback colliding with a same-cycle dispatch to the same id is dropped.
    wb_ok = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      wb_ok[i] = wb_valid_i[i] & ~c_flush_o & valid[wb_robid_i[i]]
               & ~(disp_ok[0] & (dispatch_robid_i[0] == wb_robid_i[i]))
               & ~(disp_ok[1] & (dispatch_robid_i[1] == wb_robid_i[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid           <= '0;
      done            <= '0;
      head            <= '0;
      c_retire_o      <= '0;
      c_retire_info_o <= '0;
      c_flush_o       <= 1'b0;
      c_flush_robid_o <= '0;
    end else begin
      c_retire_o      <= {r1, r0};
      c_retire_info_o <= info_nxt;
      c_flush_o       <= flush_nxt;
      c_flush_robid_o <= flush_nxt ? flush_id : '0;

      if (c_flush_o) begin
        valid <= '0;
        done  <= '0;
        head  <= '0;
      end else begin
        if (r0) valid[h0] <= 1'b0;
        if (r1) valid[h1] <= 1'b0;
        head <= r1 ? (h1 + ROB_WIDTH'(1)) : (r0 ? h1 : h0);
        for (int unsigned i = 0; i < 2; i++) begin
          if (wb_ok[i]) done[wb_robid_i[i]] <= 1'b1;
        end
        for (int unsigned i = 0; i < 2; i++) begin
          if (disp_ok[i]) begin
            valid[dispatch_robid_i[i]] <= 1'b1;
            done[dispatch_robid_i[i]]  <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (wb_ok[i]) begin
        data_q[wb_robid_i[i]] <= wb_data_i[i];
        exc[wb_robid_i[i]]    <= wb_exc_i[i];
      end
    end
    for (int unsigned i = 0; i < 2; i++) begin
      if (disp_ok[i]) begin
        exc[dispatch_robid_i[i]]       <= 1'b0;
        flush_req[dispatch_robid_i[i]] <= dispatch_flush_inst_i[i];
        arf_id[dispatch_robid_i[i]]    <= dispatch_arfid_i[i];
        wreg[dispatch_robid_i[i]]      <= dispatch_wreg_i[i];
        check[dispatch_robid_i[i]]     <= dispatch_check_i[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;

  typedef retire_pkg::retire_pkg_t info_t;

  typedef struct packed {
    logic [1:0]       dv;
    logic [1:0][5:0]  did;
    logic [1:0][4:0]  darf;
    logic [1:0]       dwreg;
    logic [1:0]       dchk;
    logic [1:0]       dfl;
    logic [1:0]       wv;
    logic [1:0][5:0]  wid;
    logic [1:0][31:0] wdata;
    logic [1:0]       wexc;
  } stim_t;

  typedef struct packed {
    logic [1:0] ret;
    info_t      i0;
    info_t      i1;
    logic       fl;
    logic [5:0] fid;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } row_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [1:0]            dispatch_valid_i;
  logic [1:0][5:0]       dispatch_robid_i;
  logic [1:0][4:0]       dispatch_arfid_i;
  logic [1:0]            dispatch_wreg_i;
  logic [1:0]            dispatch_check_i;
  logic [1:0]            dispatch_flush_inst_i;
  logic [1:0]            wb_valid_i;
  logic [1:0][5:0]       wb_robid_i;
  logic [1:0][31:0]      wb_data_i;
  logic [1:0]            wb_exc_i;
  logic [1:0]            c_retire_o;
  info_t [1:0]           c_retire_info_o;
  logic                  c_flush_o;
  logic [5:0]            c_flush_robid_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  row_t rows[$];
  exp_t sb[$];
  row_t cur;

  rob_commit #(.DEPTH(64), .ROB_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dispatch_valid_i      (dispatch_valid_i),
    .dispatch_robid_i      (dispatch_robid_i),
    .dispatch_arfid_i      (dispatch_arfid_i),
    .dispatch_wreg_i       (dispatch_wreg_i),
    .dispatch_check_i      (dispatch_check_i),
    .dispatch_flush_inst_i (dispatch_flush_inst_i),
    .wb_valid_i            (wb_valid_i),
    .wb_robid_i            (wb_robid_i),
    .wb_data_i             (wb_data_i),
    .wb_exc_i              (wb_exc_i),
    .c_retire_o            (c_retire_o),
    .c_retire_info_o       (c_retire_info_o),
    .c_flush_o             (c_flush_o),
    .c_flush_robid_o       (c_flush_robid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [5:0] id);
    return 32'hD000_0000 | {26'd0, id};
  endfunction

  function automatic logic [4:0] arf(input logic [5:0] id);
    return 5'((id % 6'd31) + 6'd1);
  endfunction

  function automatic info_t ri(input logic [4:0] a, input logic [5:0] rob, input logic wv,
                               input logic c, input logic [31:0] d);
    info_t r;
    r.arf_id = a; r.rob_id = rob; r.w_valid = wv; r.w_check = c; r.data = d;
    return r;
  endfunction

  // Row builders: fill 'cur', then commit() appends it to the vector table.
  function automatic void d(input int unsigned sl, input logic [5:0] id, input logic [4:0] a,
                            input logic wr, input logic c, input logic fl);
    cur.s.dv[sl] = 1'b1; cur.s.did[sl] = id; cur.s.darf[sl] = a;
    cur.s.dwreg[sl] = wr; cur.s.dchk[sl] = c; cur.s.dfl[sl] = fl;
  endfunction

  function automatic void w(input int unsigned sl, input logic [5:0] id, input logic [31:0] v,
                            input logic ex);
    cur.s.wv[sl] = 1'b1; cur.s.wid[sl] = id; cur.s.wdata[sl] = v; cur.s.wexc[sl] = ex;
  endfunction

  function automatic void exr(input int unsigned sl, input info_t i);
    cur.e.ret[sl] = 1'b1;
    if (sl == 0) cur.e.i0 = i; else cur.e.i1 = i;
  endfunction

  function automatic void exfl(input logic [5:0] id);
    cur.e.fl = 1'b1; cur.e.fid = id;
  endfunction

  function automatic void commit();
    rows.push_back(cur);
    cur = '0;
  endfunction

  task automatic drive(input stim_t s);
    dispatch_valid_i      = s.dv;
    dispatch_robid_i      = s.did;
    dispatch_arfid_i      = s.darf;
    dispatch_wreg_i       = s.dwreg;
    dispatch_check_i      = s.dchk;
    dispatch_flush_inst_i = s.dfl;
    wb_valid_i            = s.wv;
    wb_robid_i            = s.wid;
    wb_data_i             = s.wdata;
    wb_exc_i              = s.wexc;
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, " retire"},   64'(c_retire_o),         64'(e.ret));
    chk({tag, " info0"},    64'(c_retire_info_o[0]), 64'(e.i0));
    chk({tag, " info1"},    64'(c_retire_info_o[1]), 64'(e.i1));
    chk({tag, " flush"},    64'(c_flush_o),          64'(e.fl));
    chk({tag, " flush_id"}, 64'(c_flush_robid_o),    64'(e.fid));
  endtask

  // Each row: inputs driven at negedge, expected outputs pushed to the
  // scoreboard, popped and compared just after the following posedge.
  task automatic run_rows(input string grp);
    exp_t e;
    for (int k = 0; k < rows.size(); k++) begin
      @(negedge clk);
      drive(rows[k].s);
      sb.push_back(rows[k].e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare($sformatf("%s[%0d]", grp, k), e);
    end
    rows.delete();
    @(negedge clk);
    drive('0);
  endtask

  initial begin
    logic [5:0] a, b;
    cur = '0;
    drive('0);

    // Reset state, checked while reset is held and before any clock edge.
    #3;
    compare("reset", '0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Basic pair: writebacks in reverse order, both retire together.
    d(0, 6'd0, 5'd5, 1, 1, 0); d(1, 6'd1, 5'd6, 1, 0, 0); commit();
    w(0, 6'd1, 32'hB, 0); commit();
    w(0, 6'd0, 32'hA, 0); commit();
    exr(0, ri(5'd5, 6'd0, 1, 1, 32'hA)); exr(1, ri(5'd6, 6'd1, 1, 0, 32'hB)); commit();

    // Out-of-order completion: id3 done before id2 blocks until id2 completes.
    d(0, 6'd2, 5'd7, 1, 0, 0); d(1, 6'd3, 5'd8, 0, 1, 0); commit();
    w(1, 6'd3, 32'h33, 0); commit();
    commit();
    w(0, 6'd2, 32'h22, 0); commit();
    exr(0, ri(5'd7, 6'd2, 1, 0, 32'h22)); exr(1, ri(5'd8, 6'd3, 0, 1, 32'h33)); commit();

    // Exception at id4 stops id5 and flushes; stale id5 never retires.
    d(0, 6'd4, 5'd9, 1, 1, 0); d(1, 6'd5, 5'd10, 1, 1, 0); commit();
    w(0, 6'd4, 32'h44, 1); w(1, 6'd5, 32'h55, 0); commit();
    exr(0, ri(5'd9, 6'd4, 0, 1, 32'h44)); exfl(6'd4); commit();
    commit();
    commit();
    run_rows("basic");

    // Walk the head from 0 up to 63 in pairs plus one single.
    for (int p = 0; p < 31; p++) begin
      a = 6'(2 * p); b = 6'(2 * p + 1);
      d(0, a, arf(a), 1, a[0], 0); d(1, b, arf(b), 1, b[0], 0); commit();
      w(0, a, dat(a), 0); w(1, b, dat(b), 0); commit();
      exr(0, ri(arf(a), a, 1, a[0], dat(a))); exr(1, ri(arf(b), b, 1, b[0], dat(b))); commit();
    end
    d(0, 6'd62, arf(6'd62), 1, 0, 0); commit();
    w(0, 6'd62, dat(6'd62), 0); commit();
    exr(0, ri(arf(6'd62), 6'd62, 1, 0, dat(6'd62))); commit();
    run_rows("walk");

    // Wrap: head at 63, slot1 lands on id 0; afterwards head is 1.
    d(0, 6'd63, 5'd3, 1, 1, 0); d(1, 6'd0, 5'd4, 1, 0, 0); commit();
    w(0, 6'd0, dat(6'd0), 0); w(1, 6'd63, dat(6'd63), 0); commit();
    exr(0, ri(5'd3, 6'd63, 1, 1, dat(6'd63))); exr(1, ri(5'd4, 6'd0, 1, 0, dat(6'd0))); commit();
    d(0, 6'd1, 5'd11, 1, 1, 0); commit();
    w(1, 6'd1, dat(6'd1), 0); commit();
    exr(0, ri(5'd11, 6'd1, 1, 1, dat(6'd1))); commit();

    // arf 0 suppresses w_valid; flush_inst in slot1 flushes with slot1 id.
    d(0, 6'd2, 5'd0, 1, 0, 0); d(1, 6'd3, 5'd12, 1, 1, 1); commit();
    w(0, 6'd2, dat(6'd2), 0); w(1, 6'd3, dat(6'd3), 0); commit();
    exr(0, ri(5'd0, 6'd2, 0, 0, dat(6'd2))); exr(1, ri(5'd12, 6'd3, 1, 1, dat(6'd3)));
    exfl(6'd3); commit();
    // Dispatch during the flush cycle is ignored, so its later writeback is too.
    d(0, 6'd0, 5'd4, 1, 0, 0); commit();
    w(0, 6'd0, dat(6'd0), 0); commit();
    commit();
    // Head is back at 0.
    d(0, 6'd0, 5'd4, 1, 0, 0); commit();
    w(0, 6'd0, dat(6'd0), 0); commit();
    exr(0, ri(5'd4, 6'd0, 1, 0, dat(6'd0))); commit();
    run_rows("wrapflush");

    // Asynchronous reset with a retire on the outputs.
    d(0, 6'd1, 5'd13, 1, 0, 0); d(1, 6'd2, 5'd14, 1, 1, 0); commit();
    w(0, 6'd1, dat(6'd1), 0); w(1, 6'd2, dat(6'd2), 0); commit();
    run_rows("prerst");
    @(posedge clk);
    #1;
    chk("prerst retire", 64'(c_retire_o), 64'(2'b11));
    #2 rst = 1'b1;
    #1;
    compare("async_rst", '0);
    @(negedge clk);
    rst = 1'b0;
    w(0, 6'd0, dat(6'd0), 0); w(1, 6'd1, dat(6'd1), 0); commit();
    commit();
    commit();
    run_rows("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
